// File: rtl/wb_gpio_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the GPIO slave; grant held for a whole CYC.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_gpio_arbiter #(
   parameter int AW             = 8,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_ni,
   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   input  logic          m0_we_i,
   input  logic [AW-1:0] m0_adr_i,
   input  logic [DW-1:0] m0_dat_i,
   input  logic [3:0]    m0_sel_i,
   output logic [DW-1:0] m0_dat_o,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   input  logic          m1_we_i,
   input  logic [AW-1:0] m1_adr_i,
   input  logic [DW-1:0] m1_dat_i,
   input  logic [3:0]    m1_sel_i,
   output logic [DW-1:0] m1_dat_o,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic          s_cyc_o,
   output logic          s_stb_o,
   output logic          s_we_o,
   output logic [AW-1:0] s_adr_o,
   output logic [DW-1:0] s_dat_o,
   output logic [3:0]    s_sel_o,
   input  logic [DW-1:0] s_dat_i,
   input  logic          s_ack_i,
   input  logic          s_err_i,
   output logic [1:0]    gnt_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

   state_t state_q, state_d;
   logic   last_served_q, last_served_d;
   logic   tmo_hit_s;

   // Grant state and round-robin pointer
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q       <= IDLE;
         last_served_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
      end
   end

   // Arbitration: a release always returns to IDLE, so hand-off is never combinational
   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_d = last_served_q ? GNT0 : GNT1;
            end else if (m0_cyc_i) begin
               state_d = GNT0;
            end else if (m1_cyc_i) begin
               state_d = GNT1;
            end else begin
               state_d = IDLE;
            end
         end
         GNT0: begin
            if (!m0_cyc_i) begin
               state_d       = IDLE;
               last_served_d = 1'b0;
            end else begin
               state_d = GNT0;
            end
         end
         GNT1: begin
            if (!m1_cyc_i) begin
               state_d       = IDLE;
               last_served_d = 1'b1;
            end else begin
               state_d = GNT1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

   logic [7:0] tmo_cnt_q, tmo_cnt_d;
   logic       gstb_s;

   // Counts stalled strobe cycles of the granted master
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         tmo_cnt_q <= 8'd0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   // The counter also clears in IDLE, which covers any grant change
   always_comb begin
      tmo_cnt_d = 8'd0;
      gstb_s    = 1'b0;
      case (state_q)
         GNT0:    gstb_s = m0_stb_i;
         GNT1:    gstb_s = m1_stb_i;
         default: gstb_s = 1'b0;
      endcase
      tmo_hit_s = (state_q != IDLE) && (tmo_cnt_q == TMO_LIMIT);
      if (tmo_hit_s) begin
         tmo_cnt_d = 8'd0;
      end else if (gstb_s && !s_ack_i && !s_err_i) begin
         tmo_cnt_d = tmo_cnt_q + 8'd1;
      end else begin
         tmo_cnt_d = 8'd0;
      end
   end
`else
   assign tmo_hit_s = 1'b0;
`endif

   // Slave-side mux and return-path routing; the ungranted master sees zeros
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = 4'b0000;
      m0_dat_o = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      case (state_q)
         GNT0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i & ~tmo_hit_s;
            s_we_o   = m0_we_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i | tmo_hit_s;
         end
         GNT1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i & ~tmo_hit_s;
            s_we_o   = m1_we_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i | tmo_hit_s;
         end
         default: begin
            s_cyc_o = 1'b0;
         end
      endcase
   end

   assign gnt_o = {state_q == GNT1, state_q == GNT0};

endmodule

// File: tb/tb_wb_gpio_arbiter.sv
// Directed self-checking bench for wb_gpio_arbiter; follows WB_ARB_TIMEOUT_EN when defined.
module tb_wb_gpio_arbiter;

   logic        clk;
   logic        rst_n;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [7:0]  m0_adr, m1_adr, s_adr;
   logic [31:0] m0_dat, m1_dat, m0_rdat, m1_rdat, s_wdat, s_rdat;
   logic [3:0]  m0_sel, m1_sel, s_sel;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic        s_cyc, s_stb, s_we, s_ack, s_err;
   logic [1:0]  gnt;
   int          n_total = 0;
   int          n_bad   = 0;

   wb_gpio_arbiter #(.AW(8), .DW(32), .TIMEOUT_CYCLES(8)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
      .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
      .m0_err_o(m0_err),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
      .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
      .m1_err_o(m1_err),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
      .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_dat_i(s_rdat), .s_ack_i(s_ack),
      .s_err_i(s_err), .gnt_o(gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = 8'h00; m0_dat = 32'h0; m0_sel = 4'h0;
      m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = 8'h00; m1_dat = 32'h0; m1_sel = 4'h0;
      s_ack = 1'b0; s_err = 1'b0; s_rdat = 32'h0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      #3;
      check("rst_gnt", {30'd0, gnt}, 32'd0);
      check("rst_scyc", {31'd0, s_cyc}, 32'd0);
      check("rst_sstb", {31'd0, s_stb}, 32'd0);
      do_reset();

      // m0 single read: 1-cycle grant latency, data routed only to m0
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 8'h04; m0_sel = 4'hF;
      #1;
      check("rd_gnt_before_edge", {30'd0, gnt}, 32'd0);
      check("rd_scyc_before_edge", {31'd0, s_cyc}, 32'd0);
      tick();
      check("rd_gnt", {30'd0, gnt}, 32'd1);
      check("rd_scyc", {31'd0, s_cyc}, 32'd1);
      check("rd_sadr", {24'd0, s_adr}, 32'h04);
      check("rd_ssel", {28'd0, s_sel}, 32'hF);
      s_ack = 1'b1; s_rdat = 32'hDEADBEEF;
      #1;
      check("rd_m0dat", m0_rdat, 32'hDEADBEEF);
      check("rd_m0ack", {31'd0, m0_ack}, 32'd1);
      check("rd_m1ack", {31'd0, m1_ack}, 32'd0);
      check("rd_m1dat", m1_rdat, 32'd0);
      tick();
      s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
      tick();
      check("rd_release_gnt", {30'd0, gnt}, 32'd0);

      // contention right after reset: m0 first, one idle cycle, then m1
      do_reset();
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 8'h10;
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 8'h00; m1_dat = 32'h100;
      tick();
      check("cont_gnt_m0", {30'd0, gnt}, 32'd1);
      check("cont_sadr_m0", {24'd0, s_adr}, 32'h10);
      m0_cyc = 1'b0; m0_stb = 1'b0;
      tick();
      check("cont_idle_gnt", {30'd0, gnt}, 32'd0);
      check("cont_idle_scyc", {31'd0, s_cyc}, 32'd0);
      tick();
      check("cont_gnt_m1", {30'd0, gnt}, 32'd2);

      // m1 burst of four writes while m0 requests
      m0_cyc = 1'b1; m0_stb = 1'b1;
      for (int i = 0; i < 4; i++) begin
         m1_adr = 8'(4 * i); m1_dat = 32'h100 + 32'(i); m1_sel = 4'hF; s_ack = 1'b1;
         #1;
         check("burst_gnt", {30'd0, gnt}, 32'd2);
         check("burst_sadr", {24'd0, s_adr}, 32'(4 * i));
         check("burst_sdat", s_wdat, 32'h100 + 32'(i));
         check("burst_swe", {31'd0, s_we}, 32'd1);
         check("burst_m1ack", {31'd0, m1_ack}, 32'd1);
         check("burst_m0ack", {31'd0, m0_ack}, 32'd0);
         tick();
      end
      s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
      tick();
      check("burst_idle_gnt", {30'd0, gnt}, 32'd0);
      tick();
      check("burst_then_m0", {30'd0, gnt}, 32'd1);

      // reach GNT1 and reset mid-transfer without a clock edge
      m0_cyc = 1'b0; m0_stb = 1'b0;
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 8'h20;
      tick();
      tick();
      check("mid_gnt_m1", {30'd0, gnt}, 32'd2);
      s_ack = 1'b1; s_rdat = 32'h12345678;
      #1;
      check("mid_m1ack", {31'd0, m1_ack}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_gnt", {30'd0, gnt}, 32'd0);
      check("async_scyc", {31'd0, s_cyc}, 32'd0);
      check("async_sstb", {31'd0, s_stb}, 32'd0);
      check("async_m1ack", {31'd0, m1_ack}, 32'd0);
      check("async_m1dat", m1_rdat, 32'd0);
      s_ack = 1'b0;
      m0_cyc = 1'b1; m0_stb = 1'b1;
      #1;
      rst_n = 1'b1;
      tick();
      check("post_rst_gnt_m0", {30'd0, gnt}, 32'd1);

      // slave ack/err while IDLE never reaches a master
      do_reset();
      s_ack = 1'b1; s_err = 1'b1; s_rdat = 32'hA5A5A5A5;
      #1;
      check("idle_m0ack", {31'd0, m0_ack}, 32'd0);
      check("idle_m1ack", {31'd0, m1_ack}, 32'd0);
      check("idle_m0err", {31'd0, m0_err}, 32'd0);
      check("idle_m1err", {31'd0, m1_err}, 32'd0);
      check("idle_m0dat", m0_rdat, 32'd0);
      tick();
      check("idle_gnt_stays", {30'd0, gnt}, 32'd0);
      s_ack = 1'b0; s_err = 1'b0;

      // stalled slave on m0: err fires 8 cycles after strobe appears when the watchdog exists
      do_reset();
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 8'h08;
      tick();
      for (int k = 0; k < 11; k++) begin
         check("tmo_gnt", {30'd0, gnt}, 32'd1);
`ifdef WB_ARB_TIMEOUT_EN
         check("tmo_err", {31'd0, m0_err}, (k == 8) ? 32'd1 : 32'd0);
         check("tmo_sstb", {31'd0, s_stb}, (k == 8) ? 32'd0 : 32'd1);
`else
         check("tmo_err", {31'd0, m0_err}, 32'd0);
         check("tmo_sstb", {31'd0, s_stb}, 32'd1);
`endif
         check("tmo_m0ack", {31'd0, m0_ack}, 32'd0);
         tick();
      end
      clear_inputs();
      tick();
      check("tmo_release", {30'd0, gnt}, 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_gpio_arbiter.md
Name: wb_gpio_arbiter

Overview:
Two-master round-robin Wishbone arbiter that shares the single GPIO peripheral slave (8-bit address, 32-bit data) between master 0 (CPU data bus) and master 1 (debug/DMA port). It registers grant decisions and holds each grant for a whole cycle (CYC high), including block transfers. It muxes the granted master onto the slave port and routes ACK/ERR/data back only to that master. An optional watchdog terminates stalled slave accesses.

Parameters:
AW, 8, address width on all ports
DW, 32, data width on all ports
TIMEOUT_CYCLES, 255, stall limit for watchdog (used only with the optional feature); legal range 1..255

Ports:
wb_clk_i  in  1  system clock, all logic on rising edge
wb_rst_ni  in  1  asynchronous active-low reset
mN_cyc_i  in  1  master N cycle request (N = 0, 1; same for all mN_ lines)
mN_stb_i  in  1  master N strobe
mN_we_i  in  1  master N write enable
mN_adr_i  in  AW  master N address
mN_dat_i  in  DW  master N write data
mN_sel_i  in  4  master N byte selects
mN_dat_o  out  DW  read data to master N
mN_ack_o  out  1  ack to master N
mN_err_o  out  1  error to master N
s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
s_adr_o  out  AW  to slave
s_dat_o  out  DW  to slave
s_sel_o  out  4  to slave
s_dat_i  in  DW  slave read data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave error
gnt_o  out  2  one-hot current grant (bit0 = m0, bit1 = m1), 00 when idle

Behaviour:
- FSM states: IDLE, GNT0, GNT1. Registered state, plus a registered last_served bit.
- Async reset (wb_rst_ni = 0), including mid-transfer: state to IDLE, last_served to 1 (m0 wins the first contention), timeout counter to 0.
- During reset, all outputs are 0: s_cyc_o, s_stb_o, gnt_o, every mN_ack_o, mN_err_o and mN_dat_o.
- IDLE: all s_* outputs 0. On a clock edge with only one mN_cyc_i high, go to GNTN. With both high, grant the master that is not last_served.
- Grant latency: 1 cycle from CYC sampled in IDLE to the slave port driven. The master must hold STB until ACK/ERR, as Wishbone classic requires.
- GNTN: s_cyc/stb/we/adr/dat/sel are driven combinationally from master N. s_ack_i, s_err_i and s_dat_i are routed to master N. The other master sees ack = err = 0 and dat = 0.
- Grant is held while mN_cyc_i stays high; back-to-back STBs within one CYC are not preempted.
- When mN_cyc_i is sampled low in GNTN: go to IDLE and set last_served = N. This gives one mandatory idle cycle between grants, with no combinational grant hand-off.
- A request arriving while the other master is granted waits. After any release with both requesting, the grant alternates, which guarantees starvation freedom.
- s_ack_i or s_err_i asserted while IDLE: ignored, not forwarded to any master.
- gnt_o = {state==GNT1, state==GNT0}. It is never 11.
- Simultaneous release and request from the same master in one cycle: the master still passes through IDLE. It wins re-arbitration only if the other master is not requesting.

Optional Feature:
Macro WB_ARB_TIMEOUT_EN.
- Defined: an 8-bit counter increments each cycle in GNTN while s_stb_o = 1 and s_ack_i = s_err_i = 0. It clears on ack/err, on strobe low, or on a grant change.
- When the counter reaches TIMEOUT_CYCLES, mN_err_o is forced high for exactly one cycle, s_stb_o is held low that cycle, and the counter clears. The grant is retained; the master decides whether to drop CYC.
- Not defined: no counter is built, and mN_err_o is purely s_err_i gated by grant.

Test Plan:
- Reset then m0 single read at adr 0x04: CYC/STB at cycle 0 -> s_cyc_o = 1, gnt_o = 01 at cycle 1. Slave ack with 0xDEADBEEF -> m0_dat_o = 0xDEADBEEF, m0_ack_o = 1, m1_ack_o = 0.
- Both masters raise CYC at the same edge after reset -> m0 granted first. After m0 drops CYC: one idle cycle, then gnt_o = 10.
- m1 holds CYC for 4 back-to-back writes (adr 0x00, 0x04, 0x08, 0x0C) while m0 requests -> m0 stays ungranted until m1 releases. The slave sees all 4 writes from m1 in order.
- Assert wb_rst_ni = 0 mid-transfer while in GNT1 -> outputs go to 0 immediately without a clock. After release, contention grants m0 first.
- s_ack_i pulsed while IDLE -> no mN_ack_o asserted.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, slave never acks m0 -> m0_err_o high for exactly one cycle, 8 cycles after s_stb_o first asserts, with gnt_o still 01. Without the macro, the same stimulus stalls with no error.
